// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e : FSM state encoding (IDLE=0, RUN=1, DONE=2). The operand width
//             is a parameter of the controller and is not defined here.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder. This is the only arithmetic element of the
// serial adder.
//   a, b : addend bits
//   c    : carry in
//   sum  : sum bit
//   ca   : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic ca
);

  assign sum = a ^ b ^ c;
  assign ca  = (a & b) | (c & (a ^ b));

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Captures A, B and carry-in on an input
// handshake, adds one bit per cycle LSB first through one full_adder,
// then presents the result until the consumer takes it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (op_a, op_b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : high while an operation is in RUN or DONE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fa_sum;
  logic             w_fa_ca;
  logic [WIDTH-1:0] w_res_nxt;

  full_adder u_fa (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .c   (r_carry),
    .sum (w_fa_sum),
    .ca  (w_fa_ca)
  );

  assign w_last = (r_cnt == CNT_LAST);

  // Result shifts right; the new sum bit enters at the MSB so that after
  // WIDTH steps bit 0 holds the first (LSB) sum bit.
  always_comb begin
    w_res_nxt            = r_res >> 1;
    w_res_nxt[WIDTH-1]   = w_fa_sum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake/status decode from the state register.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand, result, carry and bit-counter datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_res   <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= op_b;
      r_carry <= cin;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (w_step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_nxt;
      r_carry <= w_fa_ca;
      // Hold on the last step so the counter never passes WIDTH-1,
      // even when WIDTH is not a power of two.
      r_cnt   <= w_last ? r_cnt : (r_cnt + CNT_ONE);
    end else begin
      r_a     <= r_a;
      r_b     <= r_b;
      r_res   <= r_res;
      r_carry <= r_carry;
      r_cnt   <= r_cnt;
    end
  end

  // The carry flop holds the final carry-out once RUN completes.
  assign sum  = r_res;
  assign cout = r_carry;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: one WIDTH=8 instance and one
// WIDTH=1 instance, driven from a vector table plus directed sequences.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
  logic [0:0] a1, b1, s1;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .op_a(a8), .op_b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(cout8), .busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .op_a(a1), .op_b(b1), .cin(cin1), .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(cout1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit d, input logic iv, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    if (d) begin
      iv1 = iv; a1 = a[0:0]; b1 = b[0:0]; cin1 = c;
    end else begin
      iv8 = iv; a8 = a; b8 = b; cin8 = c;
    end
  endtask

  task automatic set_or(input bit d, input logic v);
    if (d) or1 = v; else or8 = v;
  endtask

  function automatic logic rd_ov(input bit d);
    return d ? ov1 : ov8;
  endfunction
  function automatic logic rd_ir(input bit d);
    return d ? ir1 : ir8;
  endfunction
  function automatic logic rd_busy(input bit d);
    return d ? busy1 : busy8;
  endfunction
  function automatic logic [7:0] rd_sum(input bit d);
    return d ? {7'b0000000, s1} : s8;
  endfunction
  function automatic logic rd_cout(input bit d);
    return d ? cout1 : cout8;
  endfunction

  // Caller is positioned at a negedge; offers the operands.
  task automatic start_op(input bit d, input logic [7:0] a, input logic [7:0] b, input logic c,
                          input string name);
    chk({name, "_in_ready"}, 32'(rd_ir(d)), 32'd1);
    drive(d, 1'b1, a, b, c);
  endtask

  // Completes an offered operation: latency, result, handshake, return to IDLE.
  task automatic finish_op(input bit d, input logic [7:0] exp_sum, input logic exp_cout,
                           input string name);
    int edges;
    int lat;
    lat = d ? 2 : 9;
    @(posedge clk); #1;
    // Scramble the operand inputs; the captured values must be used.
    drive(d, 1'b0, 8'hA5, 8'h5A, 1'b1);
    edges = 1;
    chk({name, "_busy"}, 32'(rd_busy(d)), 32'd1);
    while (!rd_ov(d) && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({name, "_lat"}, 32'(edges), 32'(lat));
    chk({name, "_sum"}, 32'(rd_sum(d)), 32'(exp_sum));
    chk({name, "_cout"}, 32'(rd_cout(d)), 32'(exp_cout));
    chk({name, "_ir_done"}, 32'(rd_ir(d)), 32'd0);
    @(negedge clk); set_or(d, 1'b1);
    @(posedge clk); #1; set_or(d, 1'b0);
    chk({name, "_ov_after"}, 32'(rd_ov(d)), 32'd0);
    chk({name, "_idle"}, {30'd0, rd_ir(d), rd_busy(d)}, 32'd2);
  endtask

  initial begin
    vec_t vecs[8];
    int   ov_cycles;
    int   edges;
    logic [7:0] seen_sum;
    logic [1:0] m;
    logic ra, rb, rc;

    vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    or8 = 1'b0; or1 = 1'b0;
    #1;
    chk("rst8_outs", {27'd0, ir8, ov8, busy8, cout8, |s8}, 32'h10);
    chk("rst1_outs", {27'd0, ir1, ov1, busy1, cout1, s1[0]}, 32'h10);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven vectors on the WIDTH=8 instance.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].c, $sformatf("vec%0d", i));
      finish_op(1'b0, vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));
    end

    // Backpressure in DONE with in_valid pulses carrying other operands.
    @(negedge clk);
    start_op(1'b0, 8'h21, 8'h43, 1'b0, "bp");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    edges = 1;
    while (!ov8 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("bp_lat", 32'(edges), 32'd9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, (k % 2 == 0) ? 1'b1 : 1'b0, 8'h11, 8'h22, 1'b1);
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k), {22'd0, ov8, ir8, cout8, s8}, {22'd0, 1'b1, 1'b0, 1'b0, 8'h64});
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    or8 = 1'b1;
    @(posedge clk); #1; or8 = 1'b0;
    chk("bp_handshake", {30'd0, ov8, ir8}, 32'd1);
    ov_cycles = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ov8 || busy8) ov_cycles++;
    end
    chk("bp_no_reaccept", 32'(ov_cycles), 32'd0);

    // out_ready held high from the accept: a single DONE cycle.
    @(negedge clk);
    start_op(1'b0, 8'h0F, 8'h01, 1'b0, "early");
    or8 = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    ov_cycles = 0;
    seen_sum  = 8'h00;
    repeat (15) begin
      @(posedge clk); #1;
      if (ov8) begin
        ov_cycles++;
        seen_sum = s8;
      end
    end
    or8 = 1'b0;
    chk("early_ov_cycles", 32'(ov_cycles), 32'd1);
    chk("early_sum", 32'(seen_sum), 32'h10);
    chk("early_idle", {30'd0, ir8, busy8}, 32'd2);

    // Reset three bit-cycles into RUN.
    @(negedge clk);
    start_op(1'b0, 8'hFF, 8'h01, 1'b0, "rstrun");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrun_outs", {23'd0, ir8, ov8, busy8, cout8, s8}, {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    ov_cycles = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ov8) ov_cycles++;
    end
    chk("rstrun_no_ov", 32'(ov_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(1'b0, 8'h01, 8'h01, 1'b0, "postrst");
    finish_op(1'b0, 8'h02, 1'b0, "postrst");

    // WIDTH=1 instance.
    @(negedge clk);
    start_op(1'b1, 8'h01, 8'h01, 1'b1, "w1_111");
    finish_op(1'b1, 8'h01, 1'b1, "w1_111");
    for (int i = 0; i < 8; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      m  = {1'b0, ra} + {1'b0, rb} + {1'b0, rc};
      @(negedge clk);
      start_op(1'b1, {7'd0, ra}, {7'd0, rb}, rc, $sformatf("w1_rnd%0d", i));
      finish_op(1'b1, {7'd0, m[0]}, m[1], $sformatf("w1_rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_add_ctrl
